// File: rtl/regfile_writeback_if.sv
// Result-stream and register-file write-port bundle for regfile_writeback.
// The slave modport is the arbiter; the master modport is its environment.
interface regfile_writeback_if;
  logic        alu_valid;
  logic [3:0]  alu_index;
  logic [18:0] alu_data;
  logic        alu_ready;
  logic        ld_valid;
  logic [3:0]  ld_index;
  logic [18:0] ld_data;
  logic        ld_ready;
  logic        we;
  logic [3:0]  write_index;
  logic [18:0] write_data;
  logic [15:0] pend_mask;

  modport master (
    output alu_valid, alu_index, alu_data,
    output ld_valid, ld_index, ld_data,
    input  alu_ready, ld_ready,
    input  we, write_index, write_data, pend_mask
  );

  modport slave (
    input  alu_valid, alu_index, alu_data,
    input  ld_valid, ld_index, ld_data,
    output alu_ready, ld_ready,
    output we, write_index, write_data, pend_mask
  );
endinterface

// File: rtl/regfile_writeback.sv
// Write-back arbiter merging ALU results and buffered load returns onto the
// single register-file write port, squashing loads overtaken by ALU writes.
module regfile_writeback #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 3
) (
  input logic                clk,
  input logic                rst_n,
  regfile_writeback_if.slave rf_if
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(DEPTH);
  localparam logic [SW-1:0] LIMIT_C  = SW'(STARVE_LIMIT);
  localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);

  logic [3:0]       idx_q  [DEPTH];
  logic [18:0]      data_q [DEPTH];
  logic [DEPTH-1:0] live_q, live_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]    count_q, count_d;
  logic [SW-1:0]    starve_q, starve_d;
  logic             ready_en_q;
  logic             we_q, we_d;
  logic [3:0]       widx_q, widx_d;
  logic [18:0]      wdata_q, wdata_d;

  logic             head_present;
  logic             head_live;
  logic             head_dead;
  logic [3:0]       head_idx;
  logic [18:0]      head_data;
  logic             starve_hit;
  logic             alu_write;
  logic             push;
  logic             push_live;
  logic             pop;
  logic [15:0]      entry_mask [DEPTH];
  logic [15:0]      pend_mask;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  assign head_present = (count_q != '0);
  assign head_live    = head_present & live_q[rd_ptr_q];
  assign head_dead    = head_present & ~live_q[rd_ptr_q];
  assign head_idx     = idx_q[rd_ptr_q];
  assign head_data    = data_q[rd_ptr_q];
  assign starve_hit   = head_live & (starve_q == LIMIT_C);

  // Both ready outputs stay low until the first edge after reset release.
  assign rf_if.alu_ready = ready_en_q & ~starve_hit;
  assign rf_if.ld_ready  = ready_en_q & (count_q < DEPTH_C);

  assign alu_write = rf_if.alu_ready & rf_if.alu_valid & (rf_if.alu_index != 4'd0);
  assign push      = rf_if.ld_valid & rf_if.ld_ready & (rf_if.ld_index != 4'd0);
  // A load arriving alongside an ALU write to the same register is the older one.
  assign push_live = ~(alu_write & (rf_if.alu_index == rf_if.ld_index));

  always_comb begin
    we_d     = 1'b0;
    widx_d   = widx_q;
    wdata_d  = wdata_q;
    pop      = head_dead;
    starve_d = starve_q;
    if (starve_hit) begin
      we_d    = 1'b1;
      widx_d  = head_idx;
      wdata_d = head_data;
      pop     = 1'b1;
    end else if (alu_write) begin
      we_d    = 1'b1;
      widx_d  = rf_if.alu_index;
      wdata_d = rf_if.alu_data;
    end else if (head_live) begin
      we_d    = 1'b1;
      widx_d  = head_idx;
      wdata_d = head_data;
      pop     = 1'b1;
    end
    if (pop || !head_live) begin
      starve_d = '0;
    end else if (alu_write && (starve_q != LIMIT_C)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_comb begin
    live_d   = live_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (alu_write && (idx_q[i] == rf_if.alu_index)) begin
        live_d[i] = 1'b0;
      end
    end
    if (pop) begin
      live_d[rd_ptr_q] = 1'b0;
      rd_ptr_d         = ptr_inc(rd_ptr_q);
    end
    if (push) begin
      live_d[wr_ptr_q] = push_live;
      wr_ptr_d         = ptr_inc(wr_ptr_q);
    end
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (pop && !push) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      live_q     <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      count_q    <= '0;
      starve_q   <= '0;
      ready_en_q <= 1'b0;
      we_q       <= 1'b0;
      widx_q     <= '0;
      wdata_q    <= '0;
    end else begin
      live_q     <= live_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      count_q    <= count_d;
      starve_q   <= starve_d;
      ready_en_q <= 1'b1;
      we_q       <= we_d;
      widx_q     <= widx_d;
      wdata_q    <= wdata_d;
    end
  end

  // Payload storage needs no reset: the live bits gate every use of it.
  always_ff @(posedge clk) begin
    if (push) begin
      idx_q[wr_ptr_q]  <= rf_if.ld_index;
      data_q[wr_ptr_q] <= rf_if.ld_data;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    assign entry_mask[gi] = live_q[gi] ? (16'd1 << idx_q[gi]) : 16'd0;
  end

  always_comb begin
    pend_mask = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pend_mask = pend_mask | entry_mask[i];
    end
  end

  assign rf_if.pend_mask   = pend_mask;
  assign rf_if.we          = we_q;
  assign rf_if.write_index = widx_q;
  assign rf_if.write_data  = wdata_q;
endmodule

// File: tb/tb_regfile_writeback.sv
// Directed vector bench for regfile_writeback: table of per-cycle stimulus and
// expected outputs, plus hand-written reset and pointer-wrap sequences.
module tb_regfile_writeback;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  regfile_writeback_if rf_if ();

  regfile_writeback #(
    .DEPTH(2),
    .STARVE_LIMIT(3)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .rf_if(rf_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        av;
    logic [3:0]  ai;
    logic [18:0] ad;
    logic        lv;
    logic [3:0]  li;
    logic [18:0] ld;
    logic        we;
    logic [3:0]  wi;
    logic [18:0] wd;
    logic        ar;
    logic        lr;
    logic [15:0] pm;
  } vec_t;

  localparam int NV = 23;
  vec_t vecs [NV];

  function automatic vec_t mk(int av, int ai, int ad, int lv, int li, int ld,
                              int we, int wi, int wd, int ar, int lr, int pm);
    vec_t v;
    v.av = 1'(av);  v.ai = 4'(ai);  v.ad = 19'(ad);
    v.lv = 1'(lv);  v.li = 4'(li);  v.ld = 19'(ld);
    v.we = 1'(we);  v.wi = 4'(wi);  v.wd = 19'(wd);
    v.ar = 1'(ar);  v.lr = 1'(lr);  v.pm = 16'(pm);
    return v;
  endfunction

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int av, input int ai, input int ad,
                       input int lv, input int li, input int ld);
    rf_if.alu_valid = 1'(av);
    rf_if.alu_index = 4'(ai);
    rf_if.alu_data  = 19'(ad);
    rf_if.ld_valid  = 1'(lv);
    rf_if.ld_index  = 4'(li);
    rf_if.ld_data   = 19'(ld);
  endtask

  task automatic chk(input string name, input int tag, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s [%0d]: got 0x%0h, expected 0x%0h", name, tag, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input int tag, input int we, input int wi,
                         input int wd, input int ar, input int lr, input int pm);
    chk({name, ".we"},          tag, 32'(rf_if.we),          32'(we));
    chk({name, ".write_index"}, tag, 32'(rf_if.write_index), 32'(wi));
    chk({name, ".write_data"},  tag, 32'(rf_if.write_data),  32'(wd));
    chk({name, ".alu_ready"},   tag, 32'(rf_if.alu_ready),   32'(ar));
    chk({name, ".ld_ready"},    tag, 32'(rf_if.ld_ready),    32'(lr));
    chk({name, ".pend_mask"},   tag, 32'(rf_if.pend_mask),   32'(pm));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks = 0;
    errors = 0;

    //   alu v,idx,data        ld v,idx,data        we,idx,data           ar lr pend
    vecs[0]  = mk(1, 5, 'h7FFFF, 0, 0, 0,          1, 5, 'h7FFFF,  1, 1, 'h0000);
    vecs[1]  = mk(1, 0, 'h01234, 0, 0, 0,          0, 5, 'h7FFFF,  1, 1, 'h0000);
    vecs[2]  = mk(0, 0, 0,       0, 0, 0,          0, 5, 'h7FFFF,  1, 1, 'h0000);
    vecs[3]  = mk(1, 1, 'h00011, 1, 9, 'h00900,    1, 1, 'h00011,  1, 1, 'h0200);
    vecs[4]  = mk(1, 2, 'h00022, 1, 10, 'h00A00,   1, 2, 'h00022,  1, 0, 'h0600);
    vecs[5]  = mk(0, 0, 0,       0, 0, 0,          1, 9, 'h00900,  1, 1, 'h0400);
    vecs[6]  = mk(0, 0, 0,       0, 0, 0,          1, 10, 'h00A00, 1, 1, 'h0000);
    vecs[7]  = mk(0, 0, 0,       0, 0, 0,          0, 10, 'h00A00, 1, 1, 'h0000);
    vecs[8]  = mk(0, 0, 0,       1, 4, 'h04444,    0, 10, 'h00A00, 1, 1, 'h0010);
    vecs[9]  = mk(1, 4, 'h0AAAA, 0, 0, 0,          1, 4, 'h0AAAA,  1, 1, 'h0000);
    vecs[10] = mk(0, 0, 0,       0, 0, 0,          0, 4, 'h0AAAA,  1, 1, 'h0000);
    vecs[11] = mk(1, 4, 'h0BBBB, 1, 4, 'h0CCCC,    1, 4, 'h0BBBB,  1, 1, 'h0000);
    vecs[12] = mk(0, 0, 0,       0, 0, 0,          0, 4, 'h0BBBB,  1, 1, 'h0000);
    vecs[13] = mk(0, 0, 0,       0, 0, 0,          0, 4, 'h0BBBB,  1, 1, 'h0000);
    vecs[14] = mk(0, 0, 0,       1, 0, 'h12345,    0, 4, 'h0BBBB,  1, 1, 'h0000);
    vecs[15] = mk(0, 0, 0,       0, 0, 0,          0, 4, 'h0BBBB,  1, 1, 'h0000);
    vecs[16] = mk(1, 1, 'h10001, 1, 7, 'h07777,    1, 1, 'h10001,  1, 1, 'h0080);
    vecs[17] = mk(1, 2, 'h20002, 0, 0, 0,          1, 2, 'h20002,  1, 1, 'h0080);
    vecs[18] = mk(1, 3, 'h30003, 0, 0, 0,          1, 3, 'h30003,  1, 1, 'h0080);
    vecs[19] = mk(1, 5, 'h50005, 0, 0, 0,          1, 5, 'h50005,  0, 1, 'h0080);
    vecs[20] = mk(1, 6, 'h60006, 0, 0, 0,          1, 7, 'h07777,  1, 1, 'h0000);
    vecs[21] = mk(1, 6, 'h60006, 0, 0, 0,          1, 6, 'h60006,  1, 1, 'h0000);
    vecs[22] = mk(0, 0, 0,       0, 0, 0,          0, 6, 'h60006,  1, 1, 'h0000);

    // Power-on reset
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    repeat (3) cycle();
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #2;
    chk("release.ld_ready_before_edge", 0, 32'(rf_if.ld_ready), 32'd0);
    cycle();
    chk_all("release", 0, 0, 0, 0, 1, 1, 0);
    $display("reset released: ld_ready=%0b alu_ready=%0b", rf_if.ld_ready, rf_if.alu_ready);

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      drive(32'(vecs[i].av), 32'(vecs[i].ai), 32'(vecs[i].ad),
            32'(vecs[i].lv), 32'(vecs[i].li), 32'(vecs[i].ld));
      cycle();
      chk_all("vec", i, 32'(vecs[i].we), 32'(vecs[i].wi), 32'(vecs[i].wd),
              32'(vecs[i].ar), 32'(vecs[i].lr), 32'(vecs[i].pm));
      $display("vec %0d: we=%0b idx=%0d data=%05h alu_ready=%0b ld_ready=%0b pend=%04h",
               i, rf_if.we, rf_if.write_index, rf_if.write_data,
               rf_if.alu_ready, rf_if.ld_ready, rf_if.pend_mask);
    end

    // Pointer wrap: ten back-to-back loads, ALU idle
    for (int k = 0; k < 12; k++) begin
      if (k < 10) drive(0, 0, 0, 1, k + 1, 'h40000 | (k * 'h111));
      else        drive(0, 0, 0, 0, 0, 0);
      cycle();
      chk("wrap.ld_ready", k, 32'(rf_if.ld_ready), 32'd1);
      chk("wrap.pend_mask", k, 32'(rf_if.pend_mask), (k < 10) ? (32'd1 << (k + 1)) : 32'd0);
      if (k >= 1 && k <= 10) begin
        chk("wrap.we", k, 32'(rf_if.we), 32'd1);
        chk("wrap.write_index", k, 32'(rf_if.write_index), 32'(k));
        chk("wrap.write_data", k, 32'(rf_if.write_data), 32'('h40000 | ((k - 1) * 'h111)));
      end else begin
        chk("wrap.we", k, 32'(rf_if.we), 32'd0);
      end
      $display("wrap %0d: we=%0b idx=%0d data=%05h pend=%04h",
               k, rf_if.we, rf_if.write_index, rf_if.write_data, rf_if.pend_mask);
    end

    // Reset mid-stream with two loads buffered
    drive(1, 1, 'h00011, 1, 9, 'h00900);
    cycle();
    drive(1, 2, 'h00022, 1, 10, 'h00A00);
    cycle();
    chk_all("prefill", 0, 1, 2, 'h00022, 1, 0, 'h0600);
    drive(0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    chk_all("midreset", 0, 0, 0, 0, 0, 0, 0);
    cycle();
    cycle();
    chk_all("midreset", 1, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #1;
    chk("midrelease.ld_ready_before_edge", 0, 32'(rf_if.ld_ready), 32'd0);
    for (int j = 0; j < 3; j++) begin
      cycle();
      chk_all("post_reset", j, 0, 0, 0, 1, 1, 0);
      $display("post-reset %0d: we=%0b pend=%04h ld_ready=%0b",
               j, rf_if.we, rf_if.pend_mask, rf_if.ld_ready);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regfile_writeback.md
# regfile_writeback

Write-back arbiter sitting directly upstream of the 16-entry, 19-bit register file. It merges two result streams, always-accepted ALU results and handshaked memory-load returns, into the file's single write port (`we`, `write_index`, `write_data`). It buffers load returns in a small FIFO and squashes loads overtaken by younger ALU writes to the same register. It also reports pending-load destinations to issue logic.

## Interface
- `DEPTH`, default 2: load-return FIFO entries, ≥2.
- `STARVE_LIMIT`, default 3: consecutive cycles a live FIFO head may be blocked before the ALU is stalled.
- `clk`  in  1  system clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `alu_valid`  in  1  ALU result present; sampled only when `alu_ready`=1.
- `alu_index`  in  4  ALU destination register.
- `alu_data`  in  19  ALU result.
- `alu_ready`  out  1  ALU result accepted this cycle.
- `ld_valid`  in  1  load return present.
- `ld_index`  in  4  load destination register.
- `ld_data`  in  19  load data.
- `ld_ready`  out  1  load return accepted when `ld_valid` & `ld_ready`.
- `we`  out  1  register-file write enable, registered.
- `write_index`  out  4  register-file write index, registered.
- `write_data`  out  19  register-file write data, registered.
- `pend_mask`  out  16  bit i = live FIFO entry targets register i.

## Operation
- **Index 0 is never written.**
  - ALU result with index 0: no write, no squash, port treated as idle.
  - Load with index 0: handshake completes, data discarded, nothing pushed.
- **FIFO.**
  - Entries hold {live, index, data}, in order.
  - `ld_ready` = count < DEPTH, and is held 0 until the first clk edge after reset release.
  - No bypass: a pushed load is written to the file no earlier than the next cycle.
- **Port arbitration, each cycle, first match wins:**
  - (a) FIFO head is dead: pop it with no write. This does not use the port, so (b)/(c)/(d) also evaluate.
  - (b) `starve_cnt` == STARVE_LIMIT and a live head exists: `alu_ready`=0, the head is written and popped.
  - (c) ALU valid with nonzero index: the ALU result is written.
  - (d) Live head exists: the head is written and popped.
  - (e) Otherwise: idle, `we`=0 next cycle.
- **Squash.** An accepted ALU write to index X clears `live` on every FIFO entry with index X. This includes an entry being pushed in the same cycle, because same-cycle loads are defined older than the ALU result.
- **Starvation counter** (`starve_cnt`, saturating):
  - Increments each cycle a live head is blocked by (c).
  - Clears to 0 whenever the head pops or the FIFO has no live head.
- **`pend_mask`** is decoded from the current live FIFO entries. It is combinational from flops and excludes the output register.
- Data passes through unmodified at 19 bits; width truncation is the file's concern.

## Timing
- **Reset (rst_n=0, asynchronous):** `we`=0, `write_index`=0, `write_data`=0, `ld_ready`=0, `alu_ready`=0, `pend_mask`=0. FIFO count, pointers, `live` bits and `starve_cnt` all go to 0.
- **Reset mid-operation:** all buffered loads are lost. No write is issued after reset asserts.
- **ALU latency:** result accepted at edge N appears on `we`/`write_index`/`write_data` during cycle N+1, and the file commits it at edge N+2.
- **Load latency:** minimum 2 cycles from handshake to `we`.
- **`alu_ready`:** 1 in every cycle except (b). Upstream must hold its ALU result while `alu_ready`=0.
- **Simultaneous pop and push when full:** not possible, since `ld_ready`=0 when full.
- **Pop and push when not full:** both happen; count is unchanged.
- **Pointer wrap:** pointers wrap modulo DEPTH.
- **Output hold:** `we` is high for exactly one cycle per write. `write_index`/`write_data` hold their last values when `we`=0.

## Test plan
- **Reset:** assert `rst_n`=0 mid-stream with 2 loads buffered -> all outputs 0 immediately; `ld_ready` rises one edge after release; no stale writes afterwards.
- **ALU only:** alu (5, 0x7FFFF) then alu (0, 0x1234) -> `we`=1, index 5, data 0x7FFFF one cycle later; then `we`=0 (index 0 dropped).
- **Load fill/drain:** push loads to 9 and 10 with ALU busy -> `ld_ready`=0 and `pend_mask`=0x0600; ALU idle -> writes 9 then 10 in consecutive cycles; `pend_mask` ends at 0.
- **Squash:** load to 4 buffered, then ALU write to 4 -> ALU data written, load entry popped with no write, `pend_mask` bit 4 clears the cycle after the ALU accept. Repeat with load and ALU to index 4 in the same cycle -> same result.
- **Starvation:** live head buffered, ALU valid every cycle with nonzero index -> 3 ALU writes, then `alu_ready`=0 for one cycle while the load is written, then ALU resumes with its held result.
- **Wrap:** 10 back-to-back loads with ALU idle -> writes appear in order with index/data intact across pointer wrap, and `ld_ready` never drops.
